// File: rtl/outmem_arbiter.sv
// Arbiter/controller for the signed-LI output memory: shares the single
// address/write port between the operator write stream and a feedback reader.
module outmem_arbiter #(
    parameter int unsigned SLOTS = 19,
    parameter int unsigned LI_W  = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_req,
    input  logic            wr_req,
    input  logic [4:0]      wr_slot,
    input  logic [LI_W:0]   wr_data,
    output logic            wr_ack,
    input  logic            rd_req,
    input  logic [4:0]      rd_slot,
    output logic            rd_ack,
    output logic            rd_valid,
    output logic [LI_W:0]   rd_data,
    output logic            mem_wr,
    output logic [4:0]      mem_addr,
    output logic [LI_W:0]   mem_wdata,
    input  logic [LI_W:0]   mem_rdata,
    output logic            busy
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = LI_W + 1;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CLEAR} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   sc, sc_nxt;
    logic [AW-1:0]   addr_q;
    logic            last, last_nxt;
    logic            rd_v1, rd_z1;
    logic            wr_ok, rd_ok;

    assign wr_ok = wr_slot < AW'(SLOTS);
    assign rd_ok = rd_slot < AW'(SLOTS);

    // Sweep, arbitration and memory-port drive
    always_comb begin
        state_nxt = state;
        sc_nxt    = sc;
        last_nxt  = last;
        wr_ack    = 1'b0;
        rd_ack    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        busy      = 1'b1;
        if (!reset) begin
            mem_addr = '0;
        end else begin
            case (state)
                ST_INIT, ST_CLEAR: begin
                    mem_wr   = 1'b1;
                    mem_addr = sc;
                    if (sc == AW'(SLOTS - 1)) begin
                        sc_nxt    = '0;
                        state_nxt = ST_RUN;
                    end else begin
                        sc_nxt = sc + AW'(1);
                    end
                end
                ST_RUN: begin
                    busy = 1'b0;
                    if (clr_req) begin
                        state_nxt = ST_CLEAR;
                    end else if (wr_req && (!rd_req || !last)) begin
                        wr_ack   = 1'b1;
                        last_nxt = 1'b1;
                        if (wr_ok) begin
                            mem_wr    = 1'b1;
                            mem_addr  = wr_slot;
                            mem_wdata = wr_data;
                        end
                    end else if (rd_req) begin
                        rd_ack   = 1'b1;
                        last_nxt = 1'b0;
                        if (rd_ok) begin
                            mem_addr = rd_slot;
                        end
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    // State, held address and the two-stage read-return pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_INIT;
            sc       <= '0;
            last     <= 1'b0;
            addr_q   <= '0;
            rd_v1    <= 1'b0;
            rd_z1    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            sc       <= sc_nxt;
            last     <= last_nxt;
            addr_q   <= mem_addr;
            rd_v1    <= rd_ack;
            rd_z1    <= rd_ack && !rd_ok;
            rd_valid <= rd_v1;
            rd_data  <= (rd_v1 && !rd_z1) ? mem_rdata : DW'(0);
        end
    end
endmodule
